rv32im_exec_unit: RTL
=====================

# rv32im_exec_unit

Parametrised successor to the single-cycle integer ALU in the execute stage. Performs all RV32I register/immediate ALU operations plus the full M extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU). It adds a valid/ready input handshake, an iterative divider with a busy state, and branch-compare flags. It sits between decode and writeback; a stage-level flush aborts in-flight work.

## Interface
- XLEN, 32, datapath width; must be even and at least 8
- CNT_W, $clog2(XLEN)+1, width of the divide iteration counter
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; asynchronous, active-low
- clear_i  in  1  synchronous flush
- valid_i  in  1  operands and op presented
- ready_o  out  1  unit can accept this cycle
- op_i  in  5  op[4]=0: base op {funct7[5],funct3}; op[4]=1: M-ext op, funct3 in op[2:0]
- operand1_i  in  XLEN  rs1 / dividend
- operand2_i  in  XLEN  rs2 or immediate / divisor
- result_o  out  XLEN  registered result
- valid_o  out  1  one-cycle pulse, result_o valid
- equal_o, less_o, less_signed_o  out  1 each  registered compare flags of the accepted operands

## Operation
- Base ops: ADD 0000, SUB 1000, SLL 0001, SLT 0010 (signed), SLTU 0011 (unsigned), XOR 0100, SRL 0101, SRA 1101 (arithmetic, sign-filled), OR 0110, AND 0111. Undefined base codes produce result 0 with valid_o.
- Shift amount is operand2_i[$clog2(XLEN)-1:0].
- Multiplies use a 2·XLEN-bit product with operands extended per op. MUL returns the low half; MULH is signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned, all returning the high half.
- Divides use restoring radix-2 on magnitudes, one quotient bit per cycle, with sign fixup at the end. Quotient sign = sign1 XOR sign2; remainder sign = sign of dividend.
- Divide special cases complete in a single cycle, like base ops:
  - divisor 0: quotient all ones, remainder = dividend.
  - signed MIN / −1: quotient MIN, remainder 0.
- Flags are updated on every accept, for all ops.
- State machine:
  - IDLE: ready_o=1. On accept of a base op, multiply, or special-case divide, register result and assert valid_o on the next edge, then stay in IDLE. On accept of a normal divide, latch magnitudes and signs, load counter = XLEN, and go to DIV.
  - DIV: ready_o=0. One shift/subtract step per edge, counter decrements; at counter 1, go to FIX.
  - FIX: ready_o=0. Apply sign correction, write result_o, pulse valid_o, go to IDLE.
- valid_i while ready_o=0 is ignored; the producer must hold it.
- There is no output backpressure; the consumer takes valid_o unconditionally.

## Timing
- Reset values: result_o=0, valid_o=0, all flags 0, state IDLE, ready_o=1.
- Base, multiply, and special-case divide: accept at edge N, result and valid_o after edge N+1. Back-to-back accepts every cycle are allowed.
- Normal divide: accept at edge N; valid_o after edge N+XLEN+2 (XLEN DIV cycles plus FIX). ready_o returns to 1 in the same cycle valid_o is high.
- clear_i: takes priority over valid_i in the same cycle (nothing is accepted). Aborts DIV or FIX and returns to IDLE next edge; result_o, valid_o, and flags go to 0.
- Asynchronous reset mid-divide: everything returns to reset values immediately.
- ready_o is decoded combinationally from the state register only; it has no input-to-output path.

## Structure
- rv32im_pkg holds op code localparams, M funct3 codes, the state enum (IDLE/DIV/FIX), and the special-case constants.
- Sub-module rv32im_divider contains the iterative divider FSM, counter, and fixup, with start/done handshake. The top level holds the base ALU, the multiplier, flags, and output muxing.

## Test plan
- ADD 0xFFFFFFFF+1 -> 0 after 1 cycle. SRA 0x80000000 by 4 -> 0xF8000000. SLT −1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU −1×0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE. All at 1-cycle latency, issued back-to-back.
- DIV −7/2 -> 0xFFFFFFFD and REM −7/2 -> 0xFFFFFFFF. valid_o at exactly XLEN+2 cycles. ready_o=0 throughout, and a held valid_i is accepted when ready_o returns.
- DIVU x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/−1 -> 0x80000000, REM of the same -> 0. All at 1-cycle latency.
- clear_i asserted in cycle 10 of a divide -> no valid_o, result 0, ready_o=1 next cycle. clear_i together with valid_i -> no accept.
- rst_ni low mid-divide -> immediate reset values. Rerun at XLEN=16: DIVU 0xFFFF/3 -> 0x5555 at 18-cycle latency.

Source files
------------

// File: rtl/rv32im_pkg.sv
// Shared definitions for the RV32IM execute unit: op encodings, M-extension funct3
// codes, divider state encoding and divide special-case constants.
package rv32im_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Divide by zero yields an all-ones quotient; MIN / -1 yields a zero remainder.
  localparam logic DIV0_Q_FILL  = 1'b1;
  localparam logic OVF_REM_FILL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FIX
  } div_state_t;

  typedef enum logic [1:0] {
    DIV_NORMAL,
    DIV_BY_ZERO,
    DIV_OVERFLOW
  } div_case_t;

endpackage

// File: rtl/rv32im_divider.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on operand
// magnitudes, followed by a sign-fixup cycle that presents the result with done.
module rv32im_divider
  import rv32im_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quot, rem, dvsr, q_fix, r_fix;
  logic             neg_q, neg_r, rem_sel;
  logic [XLEN:0]    shifted, diff;

  assign shifted = {rem, quot[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_DIV;
      ST_DIV:  if (cnt == CNT_W'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      quot    <= '0;
      rem     <= '0;
      dvsr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
    end else if (start && state_q == ST_IDLE) begin
      cnt     <= CNT_W'(XLEN);
      quot    <= (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
      dvsr    <= (is_signed && divisor[XLEN-1]) ? -divisor : divisor;
      rem     <= '0;
      neg_q   <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r   <= is_signed & dividend[XLEN-1];
      rem_sel <= want_rem;
    end else if (state_q == ST_DIV) begin
      cnt <= cnt - CNT_W'(1);
      if (!diff[XLEN]) begin
        rem  <= diff[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b1};
      end else begin
        rem  <= shifted[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b0};
      end
    end
  end

  assign q_fix  = neg_q ? -quot : quot;
  assign r_fix  = neg_r ? -rem : rem;
  assign result = rem_sel ? r_fix : q_fix;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIX);

endmodule

// File: rtl/rv32im_exec_unit.sv
// RV32IM execute unit: single-cycle base ALU, multiplier and divide special cases,
// an iterative divider for the general case, and registered compare flags.
module rv32im_exec_unit
  import rv32im_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            equal_o,
  output logic            less_o,
  output logic            less_signed_o
);

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam int SHW = $clog2(XLEN);

  logic [2:0]        funct3;
  logic [SHW-1:0]    shamt;
  logic              is_div, div_signed, div_rem, accept, div_start;
  logic              div_busy, div_done;
  logic [XLEN-1:0]   div_result, single_result;
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  div_case_t         div_case;

  assign funct3     = op_i[2:0];
  assign shamt      = operand2_i[SHW-1:0];
  assign is_div     = op_i[4] & funct3[2];
  assign div_signed = ~funct3[0];
  assign div_rem    = funct3[1];

  assign accept    = valid_i & ready_o & ~clear_i;
  assign div_start = accept & is_div & (div_case == DIV_NORMAL);
  assign ready_o   = ~div_busy;

  always_comb begin
    div_case = DIV_NORMAL;
    if (operand2_i == '0)
      div_case = DIV_BY_ZERO;
    else if (div_signed && operand1_i == SIGNED_MIN && operand2_i == '1)
      div_case = DIV_OVERFLOW;
  end

  // Sign-extending both operands to 2*XLEN lets one unsigned multiplier serve
  // every signedness combination; the low 2*XLEN product bits are exact.
  assign mul_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign mul_b_signed = (funct3 == F3_MULH);
  assign mul_a   = {{XLEN{mul_a_signed & operand1_i[XLEN-1]}}, operand1_i};
  assign mul_b   = {{XLEN{mul_b_signed & operand2_i[XLEN-1]}}, operand2_i};
  assign product = mul_a * mul_b;

  always_comb begin
    single_result = '0;
    if (!op_i[4]) begin
      case (op_i[3:0])
        OP_ADD:  single_result = operand1_i + operand2_i;
        OP_SUB:  single_result = operand1_i - operand2_i;
        OP_SLL:  single_result = operand1_i << shamt;
        OP_SLT:  single_result = {{(XLEN-1){1'b0}}, $signed(operand1_i) < $signed(operand2_i)};
        OP_SLTU: single_result = {{(XLEN-1){1'b0}}, operand1_i < operand2_i};
        OP_XOR:  single_result = operand1_i ^ operand2_i;
        OP_SRL:  single_result = operand1_i >> shamt;
        OP_SRA:  single_result = $signed(operand1_i) >>> shamt;
        OP_OR:   single_result = operand1_i | operand2_i;
        OP_AND:  single_result = operand1_i & operand2_i;
        default: single_result = '0;
      endcase
    end else begin
      case (funct3)
        F3_MUL:                       single_result = product[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: single_result = product[2*XLEN-1:XLEN];
        default: begin
          case (div_case)
            DIV_BY_ZERO:  single_result = div_rem ? operand1_i : {XLEN{DIV0_Q_FILL}};
            DIV_OVERFLOW: single_result = div_rem ? {XLEN{OVF_REM_FILL}} : SIGNED_MIN;
            default:      single_result = '0;
          endcase
        end
      endcase
    end
  end

  rv32im_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) u_divider (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (clear_i),
    .start     (div_start),
    .is_signed (div_signed),
    .want_rem  (div_rem),
    .dividend  (operand1_i),
    .divisor   (operand2_i),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Flags follow every accept; a general divide leaves result_o untouched until done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o      <= '0;
      valid_o       <= 1'b0;
      equal_o       <= 1'b0;
      less_o        <= 1'b0;
      less_signed_o <= 1'b0;
    end else if (clear_i) begin
      result_o      <= '0;
      valid_o       <= 1'b0;
      equal_o       <= 1'b0;
      less_o        <= 1'b0;
      less_signed_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (div_done) begin
        result_o <= div_result;
        valid_o  <= 1'b1;
      end else if (accept) begin
        equal_o       <= (operand1_i == operand2_i);
        less_o        <= (operand1_i < operand2_i);
        less_signed_o <= ($signed(operand1_i) < $signed(operand2_i));
        if (!div_start) begin
          result_o <= single_result;
          valid_o  <= 1'b1;
        end
      end
    end
  end

endmodule
